// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the data_mem read/write/busy_wait handshake.
// Stalls the CPU while an access is in flight and flags illegal requests and timeouts.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ACK_TIMEOUT  = 4,
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_busy_wait,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy_wait
);

    localparam int unsigned MAX_TO = (ACK_TIMEOUT > BUSY_TIMEOUT) ? ACK_TIMEOUT : BUSY_TIMEOUT;
    localparam int unsigned CNT_W  = (MAX_TO < 2) ? 1 : $clog2(MAX_TO + 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              one_req;
    logic              strobe_active;

    assign one_req = cpu_read ^ cpu_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // The error-return cycle lets the CPU move past the faulting instruction.
                if (!err_q) begin
                    if (cpu_read && cpu_write) begin
                        err_d = 1'b1;
                    end else if (one_req) begin
                        state_d    = S_REQ;
                        is_write_d = cpu_write;
                        addr_d     = cpu_addr;
                        wdata_d    = cpu_wdata;
                        cnt_d      = '0;
                    end
                end
            end
            S_REQ: begin
                if (mem_busy_wait) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q >= ACK_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (!mem_busy_wait) begin
                    state_d = S_DONE;
                    if (!is_write_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (cnt_q >= BUSY_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign strobe_active = (state_q == S_REQ) || (state_q == S_WAIT);
    assign mem_read      = strobe_active && !is_write_q;
    assign mem_write     = strobe_active && is_write_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign cpu_rdata     = rdata_q;
    assign cpu_done      = (state_q == S_DONE);
    assign cpu_err       = err_q;
    // Gated by rst so the stall also reads 0 while reset is held with a request pending.
    assign cpu_busy_wait = rst && (strobe_active || ((state_q == S_IDLE) && !err_q && one_req));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a negedge-driven data_mem model.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_read = 1'b0;
    logic       cpu_write = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_busy_wait, cpu_done, cpu_err;
    logic       mem_read, mem_write;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       mem_busy_wait = 1'b0;

    logic [7:0] mem [256];
    bit         mdl_init = 1'b0;
    int         mdl_len = 0;
    int         mdl_rem = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W(8),
        .DATA_W(8),
        .ACK_TIMEOUT(4),
        .BUSY_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_read(cpu_read),
        .cpu_write(cpu_write),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_busy_wait(cpu_busy_wait),
        .cpu_done(cpu_done),
        .cpu_err(cpu_err),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_busy_wait(mem_busy_wait)
    );

    // Memory raises busy for mdl_len cycles after seeing a strobe; mdl_len == 0 never answers.
    always @(negedge clk) begin
        if (!mdl_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            mem[0]   = 8'h5A;
            mdl_init = 1'b1;
        end
        if (mem_busy_wait) begin
            if (mdl_rem > 0) mdl_rem--;
            if (mdl_rem == 0) begin
                mem_busy_wait = 1'b0;
                if (mem_write) mem[mem_addr] = mem_wdata;
                else if (mem_read) mem_rdata = mem[mem_addr];
            end
        end else if ((mem_read || mem_write) && mdl_len > 0) begin
            mem_busy_wait = 1'b1;
            mdl_rem       = mdl_len;
            mem_rdata     = 8'hA5;
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic run_access(input logic wr, input logic [7:0] a, input logic [7:0] d, input int len,
                              output int stalled, output logic seen);
        mdl_len = len;
        drive(!wr, wr, a, d);
        stalled = 0;
        seen    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (cpu_done) begin
                seen = 1'b1;
                break;
            end
            stalled++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cpu_rdata, cpu_busy_wait, cpu_done, cpu_err, mem_read, mem_write, mem_addr, mem_wdata} !== 29'h0) begin
            n_fail++;
            $display("FAIL reset_held: outputs=%h expected 0",
                     {cpu_rdata, cpu_busy_wait, cpu_done, cpu_err, mem_read, mem_write, mem_addr, mem_wdata});
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({cpu_rdata, cpu_busy_wait, cpu_done, cpu_err, mem_read, mem_write, mem_addr, mem_wdata} !== 29'h0) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%h expected 0",
                     {cpu_rdata, cpu_busy_wait, cpu_done, cpu_err, mem_read, mem_write, mem_addr, mem_wdata});
        end
    endtask

    task automatic test_store();
        int   cyc = 0;
        logic seen = 1'b0;
        mdl_len = 10;
        drive(1'b0, 1'b1, 8'h04, 8'h11);
        #1;
        n_cmp++;
        if ({cpu_busy_wait, mem_write, mem_read} !== 3'b100) begin
            n_fail++;
            $display("FAIL store_accept_cycle: busy/wr/rd=%b expected 100", {cpu_busy_wait, mem_write, mem_read});
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (cpu_done) begin
                seen = 1'b1;
                break;
            end
            cyc++;
            n_cmp++;
            if ({mem_write, mem_read, mem_addr, mem_wdata, cpu_busy_wait, cpu_err} !== {1'b1, 1'b0, 8'h04, 8'h11, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL store_in_flight cyc %0d: wr=%b rd=%b addr=%h data=%h busy=%b err=%b expected 1 0 04 11 1 0",
                         cyc, mem_write, mem_read, mem_addr, mem_wdata, cpu_busy_wait, cpu_err);
            end
        end
        n_cmp++;
        if ({seen, cyc} !== {1'b1, 32'd11}) begin
            n_fail++;
            $display("FAIL store_latency: done_seen=%b stalled=%0d expected 1 11", seen, cyc);
        end
        n_cmp++;
        if ({cpu_busy_wait, mem_write, mem_read, cpu_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL store_done_cycle: busy/wr/rd/err=%b expected 0000", {cpu_busy_wait, mem_write, mem_read, cpu_err});
        end
        n_cmp++;
        if (mem[4] !== 8'h11) begin
            n_fail++;
            $display("FAIL store_data: mem[4]=%h expected 11", mem[4]);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        n_cmp++;
        if ({cpu_done, cpu_busy_wait, mem_write} !== 3'b000) begin
            n_fail++;
            $display("FAIL store_single_done: done/busy/wr=%b expected 000", {cpu_done, cpu_busy_wait, mem_write});
        end
    endtask

    task automatic test_load();
        int   cyc;
        logic seen;
        run_access(1'b0, 8'h04, 8'h00, 3, cyc, seen);
        n_cmp++;
        if ({seen, cyc, cpu_rdata} !== {1'b1, 32'd4, 8'h11}) begin
            n_fail++;
            $display("FAIL load_result: done_seen=%b stalled=%0d rdata=%h expected 1 4 11", seen, cyc, cpu_rdata);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        run_access(1'b1, 8'h05, 8'h22, 2, cyc, seen);
        n_cmp++;
        if ({seen, cyc, cpu_rdata} !== {1'b1, 32'd3, 8'h11}) begin
            n_fail++;
            $display("FAIL load_retained: done_seen=%b stalled=%0d rdata=%h expected 1 3 11", seen, cyc, cpu_rdata);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b1, 8'h20, 8'h99);
        #1;
        n_cmp++;
        if (cpu_busy_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_busy: busy=%b expected 0", cpu_busy_wait);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_read, mem_write, cpu_busy_wait, cpu_done, cpu_err} !== 5'b00001) begin
            n_fail++;
            $display("FAIL illegal_err: rd/wr/busy/done/err=%b expected 00001",
                     {mem_read, mem_write, cpu_busy_wait, cpu_done, cpu_err});
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_read, mem_write, cpu_busy_wait, cpu_done, cpu_err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL illegal_pulse: rd/wr/busy/done/err=%b expected 00000",
                     {mem_read, mem_write, cpu_busy_wait, cpu_done, cpu_err});
        end
    endtask

    task automatic test_ack_timeout();
        int cyc = 0;
        mdl_len = 0;
        drive(1'b1, 1'b0, 8'h10, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!mem_read) break;
            cyc++;
        end
        n_cmp++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL ack_timeout_len: strobe cycles=%0d expected 4", cyc);
        end
        n_cmp++;
        if ({cpu_err, cpu_busy_wait, cpu_done, mem_write} !== 4'b1000) begin
            n_fail++;
            $display("FAIL ack_timeout_err: err/busy/done/wr=%b expected 1000", {cpu_err, cpu_busy_wait, cpu_done, mem_write});
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        n_cmp++;
        if ({cpu_err, mem_read, cpu_busy_wait} !== 3'b000) begin
            n_fail++;
            $display("FAIL ack_timeout_idle: err/rd/busy=%b expected 000", {cpu_err, mem_read, cpu_busy_wait});
        end
    endtask

    task automatic test_busy_timeout();
        int cyc = 0;
        mdl_len = 300;
        drive(1'b1, 1'b0, 8'h04, 8'h00);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!mem_read) break;
            cyc++;
        end
        n_cmp++;
        if (cyc !== 256) begin
            n_fail++;
            $display("FAIL busy_timeout_len: strobe cycles=%0d expected 256", cyc);
        end
        n_cmp++;
        if ({cpu_err, cpu_done, cpu_rdata} !== {1'b1, 1'b0, 8'h11}) begin
            n_fail++;
            $display("FAIL busy_timeout_err: err=%b done=%b rdata=%h expected 1 0 11", cpu_err, cpu_done, cpu_rdata);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!mem_busy_wait) break;
        end
        n_cmp++;
        if ({mem_busy_wait, cpu_done, cpu_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL busy_timeout_settle: mem_busy/done/err=%b expected 000", {mem_busy_wait, cpu_done, cpu_err});
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] ev = '0;
        mdl_len = 10;
        drive(1'b1, 1'b0, 8'h04, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if ({mem_read, cpu_busy_wait} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_mid_pre: rd/busy=%b expected 11", {mem_read, cpu_busy_wait});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_rdata, cpu_busy_wait, cpu_done, cpu_err, mem_read, mem_write, mem_addr, mem_wdata} !== 29'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: outputs=%h expected 0",
                     {cpu_rdata, cpu_busy_wait, cpu_done, cpu_err, mem_read, mem_write, mem_addr, mem_wdata});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        cpu_read = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            ev = ev | {cpu_done, cpu_err, mem_read, mem_write, cpu_busy_wait};
        end
        n_cmp++;
        if ({ev, cpu_rdata} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_mid_after: events done/err/rd/wr/busy=%b rdata=%h expected 00000 00", ev, cpu_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc = 0;
        int   ndone = 0;
        mdl_len = 1;
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (cpu_done) break;
            cyc++;
        end
        n_cmp++;
        if ({cpu_done, cyc, cpu_rdata} !== {1'b1, 32'd2, 8'h5A}) begin
            n_fail++;
            $display("FAIL b2b_load: done=%b stalled=%0d rdata=%h expected 1 2 5a", cpu_done, cyc, cpu_rdata);
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b1;
        cpu_addr  = 8'h01;
        cpu_wdata = 8'h33;
        @(posedge clk); #1;
        n_cmp++;
        if ({cpu_busy_wait, mem_write, mem_read, cpu_done, cpu_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL b2b_decode: busy/wr/rd/done/err=%b expected 10000",
                     {cpu_busy_wait, mem_write, mem_read, cpu_done, cpu_err});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 8'h01, 8'h33}) begin
            n_fail++;
            $display("FAIL b2b_store_start: wr=%b addr=%h data=%h expected 1 01 33", mem_write, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (cpu_done) begin
                ndone++;
                cpu_write = 1'b0;
            end
        end
        n_cmp++;
        if ({ndone, mem[1]} !== {32'd1, 8'h33}) begin
            n_fail++;
            $display("FAIL b2b_store_done: done count=%0d mem[1]=%h expected 1 33", ndone, mem[1]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_illegal();
        test_ack_timeout();
        test_busy_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
